// File: rtl/rf_wport_arbiter_if.sv
// Write-port bundle between the write-back sources and the register-file arbiter.
// RF_WPORT_CONFLICT_DET_EN adds the wr_conflict hazard flag to the bundle.
interface rf_wport_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [3:0]          req_valid;
    logic [19:0]         req_addr;
    logic [4*DATA_W-1:0] req_data;
    logic                stall;
    logic [3:0]          req_ready;
    logic [1:0]          sel;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [DATA_W-1:0]   wr_data;
`ifdef RF_WPORT_CONFLICT_DET_EN
    logic                wr_conflict;

    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, sel, wr_en, wr_addr, wr_data, wr_conflict
    );

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, sel, wr_en, wr_addr, wr_data, wr_conflict
    );
`else
    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, sel, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, sel, wr_en, wr_addr, wr_data
    );
`endif
endinterface

// File: rtl/rf_wport_arbiter.sv
// Round-robin write-port arbiter with bounded bursts in front of the register file.
// Optional macro RF_WPORT_CONFLICT_DET_EN enables the registered wr_conflict output.
module rf_wport_arbiter #(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst_n,
    rf_wport_arbiter_if.slave wp
);

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    state_e            state_q,    state_d;
    logic [1:0]        owner_q,    owner_d;
    logic [1:0]        ptr_q,      ptr_d;
    logic [3:0]        burstCnt_q, burstCnt_d;
    logic [1:0]        sel_q,      sel_d;
    logic              wrEn_q,     wrEn_d;
    logic [4:0]        wrAddr_q,   wrAddr_d;
    logic [DATA_W-1:0] wrData_q,   wrData_d;
`ifdef RF_WPORT_CONFLICT_DET_EN
    logic              conflict_q, conflict_d;
`endif

    logic [4:0]        addrArr [4];
    logic [DATA_W-1:0] dataArr [4];
    logic              keepOwner;
    logic              grantVld;
    logic [1:0]        grantIdx;
    logic [1:0]        cand;
    logic              found;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addrArr[i] = wp.req_addr[5*i +: 5];
            dataArr[i] = wp.req_data[DATA_W*i +: DATA_W];
        end
    end

    // The owner keeps the port until its budget runs out; otherwise search starts after the last grantee.
    always_comb begin
        grantVld  = 1'b0;
        grantIdx  = '0;
        cand      = '0;
        found     = 1'b0;
        keepOwner = (state_q == BURST) && wp.req_valid[owner_q] && (burstCnt_q < MaxBurst);
        if (rst_n && !wp.stall && (|wp.req_valid)) begin
            grantVld = 1'b1;
            if (keepOwner) begin
                grantIdx = owner_q;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    cand = ptr_q + 2'(k);
                    if (!found && wp.req_valid[cand]) begin
                        grantIdx = cand;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    assign wp.req_ready = grantVld ? (4'b0001 << grantIdx) : 4'b0000;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        burstCnt_d = burstCnt_q;
        sel_d      = sel_q;
        wrEn_d     = 1'b0;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
`ifdef RF_WPORT_CONFLICT_DET_EN
        conflict_d = 1'b0;
`endif
        if (grantVld) begin
            sel_d      = grantIdx;
            wrAddr_d   = addrArr[grantIdx];
            wrData_d   = dataArr[grantIdx];
            wrEn_d     = (addrArr[grantIdx] != 5'd0);
            ptr_d      = grantIdx;
            owner_d    = grantIdx;
            state_d    = BURST;
            burstCnt_d = keepOwner ? (burstCnt_q + 4'd1) : 4'd1;
`ifdef RF_WPORT_CONFLICT_DET_EN
            // A losing requester aimed at the same live register would land a stale value afterwards.
            for (int i = 0; i < 4; i++) begin
                if ((2'(i) != grantIdx) && wp.req_valid[i] &&
                    (addrArr[i] == addrArr[grantIdx]) && (addrArr[grantIdx] != 5'd0)) begin
                    conflict_d = 1'b1;
                end
            end
`endif
        end else if (!wp.stall) begin
            state_d    = IDLE;
            burstCnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= 2'd3;
            burstCnt_q <= '0;
            sel_q      <= '0;
            wrEn_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
`ifdef RF_WPORT_CONFLICT_DET_EN
            conflict_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            burstCnt_q <= burstCnt_d;
            sel_q      <= sel_d;
            wrEn_q     <= wrEn_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
`ifdef RF_WPORT_CONFLICT_DET_EN
            conflict_q <= conflict_d;
`endif
        end
    end

    assign wp.sel     = sel_q;
    assign wp.wr_en   = wrEn_q;
    assign wp.wr_addr = wrAddr_q;
    assign wp.wr_data = wrData_q;
`ifdef RF_WPORT_CONFLICT_DET_EN
    assign wp.wr_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: two instances (MAX_BURST=1 and 4) share the stimulus and
// are checked every cycle against a rule-level model plus hand-computed expectations.
module tb_rf_wport_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  valid = 4'h0;
    logic        stall = 1'b0;
    logic [4:0]  addr [4] = '{5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] data [4] = '{32'd0, 32'd0, 32'd0, 32'd0};

    int errors = 0;
    int checks = 0;

    rf_wport_arbiter_if #(.DATA_W(32)) ifRr ();
    rf_wport_arbiter_if #(.DATA_W(32)) ifBurst ();

    assign ifRr.req_valid    = valid;
    assign ifRr.stall        = stall;
    assign ifRr.req_addr     = {addr[3], addr[2], addr[1], addr[0]};
    assign ifRr.req_data     = {data[3], data[2], data[1], data[0]};
    assign ifBurst.req_valid = valid;
    assign ifBurst.stall     = stall;
    assign ifBurst.req_addr  = {addr[3], addr[2], addr[1], addr[0]};
    assign ifBurst.req_data  = {data[3], data[2], data[1], data[0]};

    rf_wport_arbiter #(.DATA_W(32), .MAX_BURST(1)) dutRr (
        .clk   (clk),
        .rst_n (rst_n),
        .wp    (ifRr)
    );

    rf_wport_arbiter #(.DATA_W(32), .MAX_BURST(4)) dutBurst (
        .clk   (clk),
        .rst_n (rst_n),
        .wp    (ifBurst)
    );

    always #5 clk = ~clk;

    logic [3:0]  dutReady [2];
    logic [1:0]  dutSel   [2];
    logic        dutWrEn  [2];
    logic [4:0]  dutAddr  [2];
    logic [31:0] dutData  [2];
    assign dutReady[0] = ifRr.req_ready;
    assign dutReady[1] = ifBurst.req_ready;
    assign dutSel[0]   = ifRr.sel;
    assign dutSel[1]   = ifBurst.sel;
    assign dutWrEn[0]  = ifRr.wr_en;
    assign dutWrEn[1]  = ifBurst.wr_en;
    assign dutAddr[0]  = ifRr.wr_addr;
    assign dutAddr[1]  = ifBurst.wr_addr;
    assign dutData[0]  = ifRr.wr_data;
    assign dutData[1]  = ifBurst.wr_data;
`ifdef RF_WPORT_CONFLICT_DET_EN
    logic dutConf [2];
    assign dutConf[0] = ifRr.wr_conflict;
    assign dutConf[1] = ifBurst.wr_conflict;
`endif

    // Model state per instance: owner -1 means nobody holds the port.
    int          mOwner [2] = '{-1, -1};
    int          mCnt   [2] = '{0, 0};
    int          mPtr   [2] = '{3, 3};
    int          mSel   [2] = '{0, 0};
    logic        mWrEn  [2] = '{1'b0, 1'b0};
    logic [4:0]  mAddr  [2] = '{5'd0, 5'd0};
    logic [31:0] mData  [2] = '{32'd0, 32'd0};
    logic        mConf  [2] = '{1'b0, 1'b0};
    int          mGrant [2];

    function automatic int maxOf(int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int grantOf(logic rs, logic [3:0] v, logic st, int owner, int cnt, int ptr, int maxB);
        if (!rs || st || v == 4'h0) return -1;
        if (owner >= 0 && v[owner] && cnt < maxB) return owner;
        for (int k = 1; k <= 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic conflictOf(logic [3:0] v, logic [19:0] ap, int g);
        logic [4:0] ga;
        ga = ap[5*g +: 5];
        for (int i = 0; i < 4; i++) begin
            if (i != g && v[i] && ap[5*i +: 5] == ga && ga != 5'd0) return 1'b1;
        end
        return 1'b0;
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            mGrant[d] = grantOf(rst_n, valid, stall, mOwner[d], mCnt[d], mPtr[d], maxOf(d));
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mOwner[d] <= -1;
                mCnt[d]   <= 0;
                mPtr[d]   <= 3;
                mSel[d]   <= 0;
                mWrEn[d]  <= 1'b0;
                mAddr[d]  <= 5'd0;
                mData[d]  <= 32'd0;
                mConf[d]  <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (mGrant[d] >= 0) begin
                    mSel[d]   <= mGrant[d];
                    mAddr[d]  <= addr[mGrant[d]];
                    mData[d]  <= data[mGrant[d]];
                    mWrEn[d]  <= (addr[mGrant[d]] != 5'd0);
                    mCnt[d]   <= (mGrant[d] == mOwner[d] && mCnt[d] < maxOf(d)) ? mCnt[d] + 1 : 1;
                    mOwner[d] <= mGrant[d];
                    mPtr[d]   <= mGrant[d];
                    mConf[d]  <= conflictOf(valid, {addr[3], addr[2], addr[1], addr[0]}, mGrant[d]);
                end else if (stall) begin
                    mWrEn[d] <= 1'b0;
                    mConf[d] <= 1'b0;
                end else begin
                    mWrEn[d]  <= 1'b0;
                    mOwner[d] <= -1;
                    mCnt[d]   <= 0;
                    mConf[d]  <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("model d%0d ready", d), 64'(dutReady[d]),
                        (mGrant[d] >= 0) ? 64'(4'b0001 << mGrant[d]) : 64'd0);
            checkOutput($sformatf("model d%0d wr_en", d), 64'(dutWrEn[d]), 64'(mWrEn[d]));
            checkOutput($sformatf("model d%0d sel", d), 64'(dutSel[d]), 64'(mSel[d]));
            checkOutput($sformatf("model d%0d wr_addr", d), 64'(dutAddr[d]), 64'(mAddr[d]));
            checkOutput($sformatf("model d%0d wr_data", d), 64'(dutData[d]), 64'(mData[d]));
`ifdef RF_WPORT_CONFLICT_DET_EN
            checkOutput($sformatf("model d%0d wr_conflict", d), 64'(dutConf[d]), 64'(mConf[d]));
`endif
        end
    end

    // Inputs change just after the falling edge; literal checks follow one step later.
    task automatic applyStimulus(input logic [3:0] v, input logic st);
        @(negedge clk);
        #1;
        valid = v;
        stall = st;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        valid = 4'h0;
        stall = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rrSeq [5];
        int         burstSeq [9];
        rrSeq    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        burstSeq = '{1, 1, 1, 1, 2, 2, 2, 2, 1};

        $display("[TB] reset and round-robin start");
        addr  = '{5'd1, 5'd2, 5'd3, 5'd4};
        data  = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
        valid = 4'hF;
        @(negedge clk);
        #2;
        checkOutput("reset ready rr", 64'(dutReady[0]), 64'd0);
        checkOutput("reset ready burst", 64'(dutReady[1]), 64'd0);
        checkOutput("reset wr_en", 64'(dutWrEn[0]), 64'd0);
        checkOutput("reset sel", 64'(dutSel[1]), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) applyStimulus(4'hF, 1'b0);
            checkOutput($sformatf("rr ready %0d", i), 64'(dutReady[0]), 64'(rrSeq[i]));
            if (i > 0) begin
                checkOutput($sformatf("rr wr_addr %0d", i), 64'(dutAddr[0]), 64'(i));
                checkOutput($sformatf("rr sel %0d", i), 64'(dutSel[0]), 64'(i - 1));
                checkOutput($sformatf("rr wr_en %0d", i), 64'(dutWrEn[0]), 64'd1);
            end
        end

        $display("[TB] burst limit");
        doReset();
        addr[1] = 5'd5;
        addr[2] = 5'd6;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'b0110, 1'b0);
            checkOutput($sformatf("burst grant %0d", i), 64'(dutReady[1]), 64'(4'b0001 << burstSeq[i]));
            if (i > 0) checkOutput($sformatf("burst wr_en %0d", i), 64'(dutWrEn[1]), 64'd1);
        end

        $display("[TB] stall mid-burst");
        doReset();
        addr[0] = 5'd9;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b0001, 1'b0);
            checkOutput($sformatf("pre-stall ready %0d", i), 64'(dutReady[1]), 64'b0001);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 1'b1);
            checkOutput($sformatf("stall ready %0d", i), 64'(dutReady[1]), 64'd0);
            checkOutput($sformatf("stall wr_en %0d", i), 64'(dutWrEn[1]), (i == 0) ? 64'd1 : 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0011, 1'b0);
            checkOutput($sformatf("resume ready %0d", i), 64'(dutReady[1]), (i < 2) ? 64'b0001 : 64'b0010);
            checkOutput($sformatf("resume wr_en %0d", i), 64'(dutWrEn[1]), (i == 0) ? 64'd0 : 64'd1);
        end

        $display("[TB] write to r0");
        doReset();
        addr[3] = 5'd0;
        data[3] = 32'hDEAD_BEEF;
        applyStimulus(4'b1000, 1'b0);
        checkOutput("r0 ready rr", 64'(dutReady[0]), 64'b1000);
        checkOutput("r0 ready burst", 64'(dutReady[1]), 64'b1000);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("r0 wr_en", 64'(dutWrEn[1]), 64'd0);
        checkOutput("r0 sel", 64'(dutSel[1]), 64'd3);
        checkOutput("r0 wr_data", 64'(dutData[1]), 64'hDEAD_BEEF);

        $display("[TB] async reset mid-burst");
        doReset();
        addr = '{5'd1, 5'd2, 5'd3, 5'd4};
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("owner kept", 64'(dutReady[1]), 64'b0100);
        checkOutput("pre-reset sel", 64'(dutSel[1]), 64'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async wr_en", 64'(dutWrEn[1]), 64'd0);
        checkOutput("async sel", 64'(dutSel[1]), 64'd0);
        checkOutput("async ready", 64'(dutReady[1]), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset grant burst", 64'(dutReady[1]), 64'b0001);
        checkOutput("post-reset grant rr", 64'(dutReady[0]), 64'b0001);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("post-reset sel", 64'(dutSel[1]), 64'd0);
        checkOutput("post-reset wr_addr", 64'(dutAddr[1]), 64'd1);

`ifdef RF_WPORT_CONFLICT_DET_EN
        $display("[TB] destination conflict");
        doReset();
        addr[0] = 5'd7;
        addr[2] = 5'd7;
        applyStimulus(4'b0101, 1'b0);
        checkOutput("conflict grant rr", 64'(dutReady[0]), 64'b0001);
        checkOutput("conflict grant burst", 64'(dutReady[1]), 64'b0001);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("conflict flag rr", 64'(dutConf[0]), 64'd1);
        checkOutput("conflict flag burst", 64'(dutConf[1]), 64'd1);
        checkOutput("second grant", 64'(dutReady[1]), 64'b0100);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("conflict clear", 64'(dutConf[1]), 64'd0);
`endif

        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
